// File: rtl/ddr3_port_arbiter.sv
// rtl/ddr3_port_arbiter.sv - round-robin burst scheduler sharing one DDR3 app interface
module ddr3_port_arbiter #(
    parameter int NPORT     = 2,
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 128,
    parameter int TAG_DEPTH = 64
) (
    input  logic                    ui_clk,
    input  logic                    rst_n,
    input  logic                    init_calib_complete,
    input  logic                    app_rdy,
    input  logic                    app_wdf_rdy,
    input  logic                    app_rd_data_valid,
    input  logic [DATA_W-1:0]       app_rd_data,
    output logic                    app_en,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    output logic [2:0]              app_cmd,
    output logic [ADDR_W-1:0]       app_addr,
    output logic [DATA_W-1:0]       app_wdf_data,
    input  logic [NPORT-1:0]        req,
    input  logic [NPORT-1:0]        req_cmd,
    input  logic [NPORT*ADDR_W-1:0] req_addr,
    input  logic [NPORT*8-1:0]      req_blen,
    output logic [NPORT-1:0]        gnt,
    output logic [NPORT-1:0]        wr_rden,
    input  logic [NPORT*DATA_W-1:0] wr_data,
    output logic [NPORT-1:0]        rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    busy,
    output logic                    tag_err
);

    localparam int IW  = (NPORT > 2) ? 2 : 1;
    localparam int TAW = $clog2(TAG_DEPTH);
    localparam logic [NPORT-1:0] ONE_P    = NPORT'(1);
    localparam logic [TAW:0]     FULL_CNT = (TAW+1)'(TAG_DEPTH);

    typedef enum logic [1:0] {
        S_WAIT_CAL = 2'd0,
        S_ARB      = 2'd1,
        S_BURST    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       last_gnt_q, last_gnt_d;
    logic [IW-1:0]       id_q, id_d;
    logic                cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          blen_q, blen_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [NPORT-1:0]    gnt_q, gnt_d;
    logic                tag_err_q, tag_err_d;
    logic [IW-1:0]       tag_mem_q [TAG_DEPTH];
    logic [IW-1:0]       tag_mem_d [TAG_DEPTH];
    logic [TAW-1:0]      wptr_q, wptr_d;
    logic [TAW-1:0]      rptr_q, rptr_d;
    logic [TAW:0]        tcnt_q, tcnt_d;

    logic                pick_vld;
    logic [IW-1:0]       pick_id;
    logic                start;
    logic                active;
    logic                tag_full;
    logic                tag_empty;
    logic                wr_acc;
    logic                rd_acc;
    logic                beat;
    logic                last_beat;
    logic                tag_pop;
    logic [IW-1:0]       tag_head;

    // Scan from last_gnt+1 upward with wrap; the descending loop leaves the nearest requester.
    always_comb begin
        int idx;
        logic [NPORT-1:0] req_sh;
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = 0;
        req_sh   = '0;
        for (int i = NPORT; i >= 1; i--) begin
            idx    = (int'(last_gnt_q) + i) % NPORT;
            req_sh = req >> idx;
            if (req_sh[0]) begin
                pick_vld = 1'b1;
                pick_id  = IW'(idx);
            end
        end
    end

    assign start     = (state_q == S_ARB) && init_calib_complete && pick_vld;
    assign active    = (state_q == S_BURST) && (blen_q != 8'd0);
    assign tag_full  = (tcnt_q == FULL_CNT);
    assign tag_empty = (tcnt_q == '0);
    assign wr_acc    = active && !cmd_q && app_rdy && app_wdf_rdy;
    assign rd_acc    = active && cmd_q && app_rdy && !tag_full;
    assign beat      = wr_acc || rd_acc;
    assign last_beat = beat && (cnt_q == blen_q - 8'd1);
    assign tag_head  = tag_mem_q[rptr_q];
    assign tag_pop   = app_rd_data_valid && !tag_empty;

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT_CAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_CAL: if (init_calib_complete) state_d = S_ARB;
            S_ARB:      if (start) state_d = S_BURST;
            S_BURST:    if ((blen_q == 8'd0) || last_beat) state_d = S_ARB;
            default:    state_d = S_WAIT_CAL;
        endcase
    end

    always_comb begin
        busy         = (state_q != S_ARB);
        gnt          = gnt_q;
        app_en       = beat;
        app_wdf_wren = wr_acc;
        app_wdf_end  = wr_acc;
        app_cmd      = {2'b00, cmd_q};
        app_addr     = addr_q;
        app_wdf_data = DATA_W'(wr_data >> (int'(id_q) * DATA_W));
        wr_rden      = wr_acc ? (ONE_P << id_q) : '0;
        rd_valid     = tag_pop ? (ONE_P << tag_head) : '0;
        rd_data      = app_rd_data;
        tag_err      = tag_err_q;
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        id_d       = id_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        blen_d     = blen_q;
        cnt_d      = cnt_q;
        gnt_d      = '0;
        if (start) begin
            id_d       = pick_id;
            cmd_d      = req_cmd[pick_id];
            addr_d     = ADDR_W'(req_addr >> (int'(pick_id) * ADDR_W));
            blen_d     = 8'(req_blen >> (int'(pick_id) * 8));
            cnt_d      = 8'd0;
            gnt_d      = ONE_P << pick_id;
            last_gnt_d = pick_id;
        end else if (beat) begin
            addr_d = addr_q + ADDR_W'(8);
            cnt_d  = cnt_q + 8'd1;
        end
    end

    // Tag FIFO: port id of every issued read beat, popped in order as data returns.
    always_comb begin
        tag_mem_d = tag_mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        tcnt_d    = tcnt_q;
        tag_err_d = tag_err_q || (app_rd_data_valid && tag_empty);
        if (rd_acc) begin
            tag_mem_d[wptr_q] = id_q;
            wptr_d            = wptr_q + TAW'(1);
        end
        if (tag_pop) begin
            rptr_d = rptr_q + TAW'(1);
        end
        case ({rd_acc, tag_pop})
            2'b10:   tcnt_d = tcnt_q + (TAW+1)'(1);
            2'b01:   tcnt_d = tcnt_q - (TAW+1)'(1);
            default: tcnt_d = tcnt_q;
        endcase
    end

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= IW'(NPORT - 1);
            id_q       <= '0;
            cmd_q      <= 1'b0;
            addr_q     <= '0;
            blen_q     <= 8'd0;
            cnt_q      <= 8'd0;
            gnt_q      <= '0;
            tag_err_q  <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            tcnt_q     <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            last_gnt_q <= last_gnt_d;
            id_q       <= id_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            blen_q     <= blen_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            tag_err_q  <= tag_err_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            tcnt_q     <= tcnt_d;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_q[i] <= tag_mem_d[i];
            end
        end
    end

endmodule
